serial_subtractor: RTL

//   Bit-serial WIDTH-bit subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = A - B - Bin, borrow out of the bit.
// Ports: A, B, Bin in; diff, borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic diff,
  output logic borrow
);

  assign diff   = A ^ B ^ Bin;
  assign borrow = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit/clock.
// Ports: clk, rst_n, start, a, b in; busy, done, diff, borrow_out out;
// overflow out only when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_res;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;
  logic             w_load;
  logic             w_last;

  full_subtractor u_fs (
    .A      (r_a_sr[0]),
    .B      (r_b_sr[0]),
    .Bin    (r_brw),
    .diff   (w_d),
    .borrow (w_bo)
  );

  assign w_load = start && (r_state != SHIFT);
  assign w_last = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_res  = {w_d, r_r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_r_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_r_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_r_sr <= w_res;
      r_brw  <= w_bo;
      // wrap to 0 on the last bit so cnt stays within 0..WIDTH-1
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res;
        r_bout <= w_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // operand MSBs are shifted out, so keep copies for the overflow term
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign overflow = r_ovf;
`endif

  assign busy       = (r_state == SHIFT);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule
